// File: rtl/regfile_multiport_if.sv
// Register file bus: groups the writeback, reserve and read signals of
// regfile_multiport into one bundle.
//   master : decode/writeback side. It drives the write, reserve and read
//            addresses, and receives ready, read data and pending flags.
//   slave  : the register file itself.
// Handshake semantics: there is no valid/ready flow control on this bus.
// write_enable and reserve_enable are single-cycle strobes sampled at the
// rising clock edge, and only while ready is high. Reads are combinational
// and always accepted. ready means the post-reset clear has finished.
interface regfile_multiport_if #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int READ_PORTS = 2
);
    logic                         ready;
    logic                         write_enable;
    logic [AW-1:0]                write_address;
    logic [XLEN-1:0]              write_data;
    logic                         reserve_enable;
    logic [AW-1:0]                reserve_address;
    logic [READ_PORTS*AW-1:0]     read_address;
    logic [READ_PORTS*XLEN-1:0]   read_data;
    logic [READ_PORTS-1:0]        read_pending;

    modport master (
        input  ready, read_data, read_pending,
        output write_enable, write_address, write_data,
               reserve_enable, reserve_address, read_address
    );

    modport slave (
        output ready, read_data, read_pending,
        input  write_enable, write_address, write_data,
               reserve_enable, reserve_address, read_address
    );
endinterface

// File: rtl/regfile_multiport.sv
// Parametrised RV32I/RV32E integer register file.
// It has READ_PORTS combinational read ports, one writeback port with
// same-cycle bypass, and a per-register pending scoreboard for multi-cycle
// producers. After reset it runs a clear sequence that writes every register
// from x1 upward. x2 receives SP_INIT and every other register receives 0.
// ready rises when the clear sequence is done.
// Ports:
//   clock       : rising-edge clock
//   reset       : asynchronous, active-high
//   debug_state : 1 while the state machine is in RUN, 0 while in CLEAR
//   rf          : regfile_multiport_if slave modport. It carries ready,
//                 write_*, reserve_*, read_address, read_data and
//                 read_pending.
module regfile_multiport #(
    parameter int              XLEN       = 32,
    parameter int              NUM_REGS   = 32,
    parameter int              READ_PORTS = 2,
    parameter logic [XLEN-1:0] SP_INIT    = '0
) (
    input  logic               clock,
    input  logic               reset,
    output logic               debug_state,
    regfile_multiport_if.slave rf
);
    localparam int AW = $clog2(NUM_REGS);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       count_q, count_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [XLEN-1:0]     regs_q [NUM_REGS];

    // Single array write port. The clear sequence and writeback share it.
    logic                reg_we;
    logic [AW-1:0]       reg_wa;
    logic [XLEN-1:0]     reg_wd;
    logic                run;

    assign run         = (state_q == ST_RUN);
    assign rf.ready    = run;
    assign debug_state = run;

    // Next-state, clear sequence, writeback and scoreboard update.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pending_d = pending_q;
        reg_we    = 1'b0;
        reg_wa    = rf.write_address;
        reg_wd    = rf.write_data;
        case (state_q)
            ST_CLEAR: begin
                // Write and reserve strobes are ignored here.
                reg_we  = 1'b1;
                reg_wa  = count_q;
                reg_wd  = (count_q == AW'(2)) ? SP_INIT : '0;
                count_d = count_q + AW'(1);
                if (count_q == AW'(NUM_REGS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rf.write_enable && (rf.write_address != '0)) begin
                    reg_we                      = 1'b1;
                    pending_d[rf.write_address] = 1'b0;
                end
                // Applied after the write clear. When both strobes hit the
                // same register, the new producer's reservation is kept.
                if (rf.reserve_enable && (rf.reserve_address != '0)) begin
                    pending_d[rf.reserve_address] = 1'b1;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            count_q   <= AW'(1);
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    // The storage array has no reset. The clear sequence initialises it
    // before any read can observe it.
    always_ff @(posedge clock) begin
        if (reg_we) begin
            regs_q[reg_wa] <= reg_wd;
        end
    end

    // Combinational read ports. A port reads 0 while clearing and for x0.
    // A same-cycle writeback to the read register is bypassed and shows as
    // no longer pending.
    always_comb begin
        rf.read_data    = '0;
        rf.read_pending = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            if (run && (rf.read_address[p*AW +: AW] != '0)) begin
                if (rf.write_enable &&
                    (rf.write_address == rf.read_address[p*AW +: AW])) begin
                    rf.read_data[p*XLEN +: XLEN] = rf.write_data;
                end else begin
                    rf.read_data[p*XLEN +: XLEN] = regs_q[rf.read_address[p*AW +: AW]];
                    rf.read_pending[p]           = pending_q[rf.read_address[p*AW +: AW]];
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;
    localparam logic [31:0] SP_A = 32'h1000_0000;
    localparam logic [31:0] SP_B = 32'h0000_0FF0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic dbg_a, dbg_b;

    int cmp_count = 0;
    int err_count = 0;

    always #5 clock = ~clock;

    regfile_multiport_if #(.XLEN(32), .AW(5), .READ_PORTS(2)) ifa ();
    regfile_multiport_if #(.XLEN(32), .AW(4), .READ_PORTS(4)) ifb ();

    regfile_multiport #(.XLEN(32), .NUM_REGS(32), .READ_PORTS(2), .SP_INIT(SP_A)) dut_a (
        .clock(clock), .reset(reset), .debug_state(dbg_a), .rf(ifa)
    );
    regfile_multiport #(.XLEN(32), .NUM_REGS(16), .READ_PORTS(4), .SP_INIT(SP_B)) dut_b (
        .clock(clock), .reset(reset), .debug_state(dbg_b), .rf(ifb)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        cmp_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Index 0 models dut_a and index 1 models dut_b.
    // ready depends only on how many edges have passed since reset release.
    // Contents are the post-clear image updated by writes and reserves.
    int          num_regs [2] = '{32, 16};
    int          num_ports[2] = '{2, 4};
    logic [31:0] sp_val   [2] = '{SP_A, SP_B};
    logic [31:0] m_regs [2][32];
    bit          m_pend [2][32];
    int          m_cyc  [2];

    function automatic bit in_we(int d);          return d == 0 ? ifa.write_enable : ifb.write_enable; endfunction
    function automatic int in_wa(int d);          return d == 0 ? int'(ifa.write_address) : int'(ifb.write_address); endfunction
    function automatic logic [31:0] in_wd(int d); return d == 0 ? ifa.write_data : ifb.write_data; endfunction
    function automatic bit in_re(int d);          return d == 0 ? ifa.reserve_enable : ifb.reserve_enable; endfunction
    function automatic int in_ra(int d);          return d == 0 ? int'(ifa.reserve_address) : int'(ifb.reserve_address); endfunction
    function automatic int in_rd_addr(int d, int p);
        return d == 0 ? int'(ifa.read_address[p*5 +: 5]) : int'(ifb.read_address[p*4 +: 4]);
    endfunction
    function automatic logic [31:0] out_data(int d, int p);
        return d == 0 ? ifa.read_data[p*32 +: 32] : ifb.read_data[p*32 +: 32];
    endfunction
    function automatic logic out_pend(int d, int p);
        return d == 0 ? ifa.read_pending[p] : ifb.read_pending[p];
    endfunction
    function automatic logic out_ready(int d);
        return d == 0 ? ifa.ready : ifb.ready;
    endfunction

    function automatic bit model_ready(int d);
        return !reset && (m_cyc[d] >= num_regs[d] - 1);
    endfunction

    always @(posedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_cyc[d] = 0;
                for (int r = 0; r < 32; r++) begin
                    m_regs[d][r] = '0;
                    m_pend[d][r] = 1'b0;
                end
                m_regs[d][2] = sp_val[d];
            end else begin
                if (m_cyc[d] >= num_regs[d] - 1) begin
                    if (in_we(d) && in_wa(d) != 0) begin
                        m_regs[d][in_wa(d)] = in_wd(d);
                        m_pend[d][in_wa(d)] = 1'b0;
                    end
                    if (in_re(d) && in_ra(d) != 0) m_pend[d][in_ra(d)] = 1'b1;
                end
                if (m_cyc[d] < 1000) m_cyc[d]++;
            end
        end
    end

    // Every-cycle compare of all outputs against the model.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            bit rdy;
            rdy = model_ready(d);
            check($sformatf("model ready dut%0d", d), 32'(out_ready(d)), 32'(rdy));
            for (int p = 0; p < num_ports[d]; p++) begin
                int          a;
                logic [31:0] ed;
                logic        ep;
                a = in_rd_addr(d, p);
                if (!rdy || a == 0) begin
                    ed = '0;
                    ep = 1'b0;
                end else if (in_we(d) && in_wa(d) == a) begin
                    ed = in_wd(d);
                    ep = 1'b0;
                end else begin
                    ed = m_regs[d][a];
                    ep = m_pend[d][a];
                end
                check($sformatf("model data dut%0d p%0d x%0d", d, p, a), out_data(d, p), ed);
                check($sformatf("model pend dut%0d p%0d x%0d", d, p, a), 32'(out_pend(d, p)), 32'(ep));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ifa.write_enable = 1'b0; ifa.write_address = '0; ifa.write_data = '0;
        ifa.reserve_enable = 1'b0; ifa.reserve_address = '0;
        ifb.write_enable = 1'b0; ifb.write_address = '0; ifb.write_data = '0;
        ifb.reserve_enable = 1'b0; ifb.reserve_address = '0;
    endtask

    initial begin
        int a_low;
        int b_low;
        idle_inputs();
        ifa.read_address = '0;
        ifb.read_address = '0;

        // Reset state.
        repeat (3) tick();
        ifa.read_address = {5'd2, 5'd2};
        ifb.read_address = {4'd2, 4'd2, 4'd2, 4'd2};
        @(negedge clock);
        check("reset ready a", 32'(ifa.ready), 32'd0);
        check("reset ready b", 32'(ifb.ready), 32'd0);
        check("reset data a", ifa.read_data[31:0], 32'd0);
        check("reset pend b", 32'(ifb.read_pending), 32'd0);

        // Release, then re-assert reset in the middle of the clear.
        tick();
        reset = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        @(negedge clock);
        check("mid-clear reset ready a", 32'(ifa.ready), 32'd0);
        tick();
        reset = 1'b0;

        // Count cycles with ready low. Attempt a write during the clear.
        a_low = 0;
        b_low = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clock);
            if (!ifa.ready) a_low++;
            if (!ifb.ready) b_low++;
            if (ifa.ready) break;
            tick();
            if (k == 3) begin
                ifa.write_enable = 1'b1; ifa.write_address = 5'd5; ifa.write_data = 32'hDEAD_BEEF;
            end
            if (k == 6) ifa.write_enable = 1'b0;
        end
        ifa.write_enable = 1'b0;
        check("ready a after clear", 32'(ifa.ready), 32'd1);
        check("clear cycles a", 32'(a_low), 32'd31);
        check("clear cycles b", 32'(b_low), 32'd15);

        // Post-clear image. Every register is 0 except x2.
        for (int i = 0; i < 32; i++) begin
            tick();
            ifa.read_address = {5'(i), 5'(i)};
            ifb.read_address = {4'(i), 4'(i), 4'(i), 4'(i)};
            @(negedge clock);
            check($sformatf("clear a x%0d", i), ifa.read_data[31:0], (i == 2) ? SP_A : 32'd0);
            check($sformatf("clear a p1 x%0d", i), ifa.read_data[63:32], (i == 2) ? SP_A : 32'd0);
            if (i < 16) check($sformatf("clear b p3 x%0d", i), ifb.read_data[127:96], (i == 2) ? SP_B : 32'd0);
        end

        // Write x5, then read it on both ports.
        tick();
        ifa.write_enable = 1'b1; ifa.write_address = 5'd5; ifa.write_data = 32'hDEAD_BEEF;
        ifa.read_address = {5'd5, 5'd5};
        tick();
        ifa.write_enable = 1'b0;
        @(negedge clock);
        check("x5 p0", ifa.read_data[31:0], 32'hDEAD_BEEF);
        check("x5 p1", ifa.read_data[63:32], 32'hDEAD_BEEF);

        // Same-cycle bypass of x7.
        tick();
        ifa.write_enable = 1'b1; ifa.write_address = 5'd7; ifa.write_data = 32'h1234_5678;
        ifa.read_address = {5'd7, 5'd7};
        @(negedge clock);
        check("bypass x7 p0", ifa.read_data[31:0], 32'h1234_5678);
        check("bypass x7 p1", ifa.read_data[63:32], 32'h1234_5678);

        // Writes to x0 are dropped.
        tick();
        ifa.write_address = 5'd0; ifa.write_data = 32'hFFFF_FFFF;
        ifa.read_address = {5'd7, 5'd0};
        @(negedge clock);
        check("x0 bypass data", ifa.read_data[31:0], 32'd0);
        check("x0 bypass pend", 32'(ifa.read_pending[0]), 32'd0);
        tick();
        ifa.write_enable = 1'b0;
        @(negedge clock);
        check("x0 after write", ifa.read_data[31:0], 32'd0);
        check("x7 stored", ifa.read_data[63:32], 32'h1234_5678);

        // Scoreboard: reserve x3 and read it on port 0.
        tick();
        ifa.reserve_enable = 1'b1; ifa.reserve_address = 5'd3;
        ifa.read_address = {5'd4, 5'd3};
        @(negedge clock);
        check("x3 pend before edge", 32'(ifa.read_pending[0]), 32'd0);
        tick();
        ifa.reserve_enable = 1'b0;
        @(negedge clock);
        check("x3 pend after reserve", 32'(ifa.read_pending[0]), 32'd1);
        check("x4 not pend", 32'(ifa.read_pending[1]), 32'd0);
        tick();
        @(negedge clock);
        check("x3 still pend", 32'(ifa.read_pending[0]), 32'd1);
        tick();
        ifa.write_enable = 1'b1; ifa.write_address = 5'd3; ifa.write_data = 32'h0000_00A5;
        @(negedge clock);
        check("x3 wb data", ifa.read_data[31:0], 32'h0000_00A5);
        check("x3 wb pend", 32'(ifa.read_pending[0]), 32'd0);
        tick();
        ifa.write_enable = 1'b0;
        @(negedge clock);
        check("x3 after wb data", ifa.read_data[31:0], 32'h0000_00A5);
        check("x3 after wb pend", 32'(ifa.read_pending[0]), 32'd0);

        // Reserve and write x3 in the same cycle: the reserve wins.
        tick();
        ifa.reserve_enable = 1'b1; ifa.reserve_address = 5'd3;
        ifa.write_enable = 1'b1; ifa.write_address = 5'd3; ifa.write_data = 32'h0000_005A;
        @(negedge clock);
        check("x3 same-cycle bypass", ifa.read_data[31:0], 32'h0000_005A);
        tick();
        ifa.reserve_enable = 1'b0; ifa.write_enable = 1'b0;
        @(negedge clock);
        check("x3 same-cycle data", ifa.read_data[31:0], 32'h0000_005A);
        check("x3 same-cycle pend", 32'(ifa.read_pending[0]), 32'd1);

        // Reserving x0 never marks it pending.
        tick();
        ifa.reserve_enable = 1'b1; ifa.reserve_address = 5'd0;
        ifa.read_address = {5'd0, 5'd3};
        tick();
        ifa.reserve_enable = 1'b0;
        @(negedge clock);
        check("x0 never pend", 32'(ifa.read_pending[1]), 32'd0);

        // Four-port config: x1, x2, x15, x0 on ports 0..3.
        tick();
        ifb.write_enable = 1'b1; ifb.write_address = 4'd1; ifb.write_data = 32'hCAFE_F00D;
        tick();
        ifb.write_address = 4'd15; ifb.write_data = 32'h0BAD_C0DE;
        tick();
        ifb.write_enable = 1'b0;
        ifb.read_address = {4'd0, 4'd15, 4'd2, 4'd1};
        @(negedge clock);
        check("b p0 x1", ifb.read_data[31:0], 32'hCAFE_F00D);
        check("b p1 x2", ifb.read_data[63:32], SP_B);
        check("b p2 x15", ifb.read_data[95:64], 32'h0BAD_C0DE);
        check("b p3 x0", ifb.read_data[127:96], 32'd0);

        // Mixed traffic on both instances, checked by the model.
        for (int k = 0; k < 60; k++) begin
            tick();
            ifa.write_enable    = 1'($urandom_range(0, 1));
            ifa.write_address   = 5'($urandom_range(0, 31));
            ifa.write_data      = $urandom;
            ifa.reserve_enable  = ($urandom_range(0, 3) == 0);
            ifa.reserve_address = 5'($urandom_range(0, 31));
            ifa.read_address    = 10'($urandom_range(0, 1023));
            ifb.write_enable    = 1'($urandom_range(0, 1));
            ifb.write_address   = 4'($urandom_range(0, 15));
            ifb.write_data      = $urandom;
            ifb.reserve_enable  = ($urandom_range(0, 3) == 0);
            ifb.reserve_address = 4'($urandom_range(0, 15));
            ifb.read_address    = 16'($urandom_range(0, 65535));
        end
        tick();
        idle_inputs();

        // Reset while x4 is pending discards the pending state and the data.
        tick();
        ifa.reserve_enable = 1'b1; ifa.reserve_address = 5'd4;
        ifa.write_enable = 1'b1; ifa.write_address = 5'd5; ifa.write_data = 32'h5555_AAAA;
        tick();
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        check("reset again ready a", 32'(ifa.ready), 32'd0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clock);
            if (ifa.ready) break;
            tick();
        end
        check("ready a after re-clear", 32'(ifa.ready), 32'd1);
        tick();
        ifa.read_address = {5'd2, 5'd4};
        @(negedge clock);
        check("x4 pend cleared", 32'(ifa.read_pending[0]), 32'd0);
        check("x4 data cleared", ifa.read_data[31:0], 32'd0);
        check("x2 re-init", ifa.read_data[63:32], SP_A);
        tick();
        ifa.read_address = {5'd5, 5'd5};
        @(negedge clock);
        check("x5 re-cleared", ifa.read_data[31:0], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end
endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised integer register file for the RV32I/RV32E core, the successor of the original 2-read/1-write array. It adds configurable width, depth and read-port count, an automatic post-reset clear sequence with a `ready` flag, and same-cycle write-to-read bypass. It also adds a per-register pending scoreboard, so multi-cycle producers (loads, future mul/div) can mark a destination busy until writeback. It sits between decode (reads, reserves) and writeback (writes).

## Interface
- XLEN, 32, register width in bits
- NUM_REGS, 32, architectural register count (16 for RV32E); power of two, ≥4
- READ_PORTS, 2, number of independent read ports (1..4)
- SP_INIT, 0, value loaded into x2 by the clear sequence
- Derived: AW = $clog2(NUM_REGS)

- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- ready  output  1  high once the clear sequence has finished
- write_enable  input  1  writeback strobe
- write_address  input  AW  writeback destination
- write_data  input  XLEN  writeback value
- reserve_enable  input  1  mark a destination pending
- reserve_address  input  AW  destination to mark pending
- read_address  input  READ_PORTS*AW  packed read addresses; port p uses bits [p*AW +: AW]
- read_data  output  READ_PORTS*XLEN  packed read data
- read_pending  output  READ_PORTS  per port: source register still awaiting writeback

## Operation
- State machine has two states, CLEAR and RUN.
- Reset: state=CLEAR, clear counter=1, every pending bit=0, ready=0.
- CLEAR state:
  - Each cycle writes 0 to register[counter], except x2, which receives SP_INIT.
  - Counter increments each cycle; after NUM_REGS-1 writes, go to RUN.
  - While in CLEAR: write_enable and reserve_enable are ignored, read_data=0, read_pending=0.
- RUN state: ready=1.
- Writes: write_enable with write_address≠0 stores write_data at the clock edge and clears pending[write_address].
- x0: never stored, never pending, always reads 0.
- Reserve: reserve_enable with reserve_address≠0 sets pending[reserve_address] at the clock edge.
- Reserve and write to the same address in the same cycle: data is stored and the pending bit ends set (reserve wins; a new producer is in flight).
- Reads (combinational, per port p, address a):
  - a=0 → data 0, pending 0.
  - write_enable and write_address=a in RUN → data=write_data (bypass), pending=0.
  - Otherwise data=register[a], pending=pending[a].
- Reset mid-operation: clear restarts from register 1; any in-progress clear or pending state is discarded.

## Timing
- Reset values: ready=0, read_data=0, read_pending=0.
- ready rises NUM_REGS-1 cycles after the first rising edge with reset low (31 cycles at default).
- Read latency is 0 cycles (combinational from read_address, plus write_* for bypass).
- Write and reserve take effect at the rising edge, visible through the array the following cycle.
- A reserve made at edge N shows as pending on reads from cycle N+1 until the cycle of the matching write, which is bypassed with pending=0.
- Every read port is independent; all ports may read the same address simultaneously.

## Test plan
- Reset with defaults, release: ready=0 for 31 cycles, then 1; all registers read 0 except x2=SP_INIT. Re-assert reset at cycle 10 → ready drops, and the full 31-cycle clear restarts.
- Clear sequence: write x5=0xDEADBEEF during CLEAR → ignored. After ready: write x5=0xDEADBEEF, next cycle ports 0 and 1 both read x5 → 0xDEADBEEF.
- Bypass: same cycle write x7=0x12345678 and read x7 → read_data=0x12345678 immediately. Write x0=0xFFFFFFFF → x0 reads 0, pending 0.
- Scoreboard: reserve x3 → next cycle read_pending=1 for x3. Write x3=0xA5 three cycles later → pending=0 and data 0xA5 in the write cycle. Reserve x3 and write x3 in the same cycle → data stored, pending stays 1.
- Parameters: NUM_REGS=16, READ_PORTS=4, XLEN=32 → ready after 15 cycles. Four ports reading x1, x2, x15, x0 return the stored values / SP_INIT / 0.
